frame_pipe_sequencer: RTL and testbench

FRAME_PIPE_SEQUENCER -- requirements
Module: frame_pipe_sequencer

---
 rtl/frame_seq_pkg.sv | 29 ++
 rtl/stage_timer.sv | 28 ++
 rtl/frame_pipe_sequencer.sv | 128 ++++++++++++
 tb/tb_frame_pipe_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// Shared state codes, watchdog default and stage-ordering helper for the
// frame pipeline sequencer.
package frame_seq_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CAP_REQ = 3'd1,
      CAP_ACK = 3'd2,
      FLT_REQ = 3'd3,
      FLT_ACK = 3'd4,
      MM_REQ  = 3'd5,
      MM_ACK  = 3'd6,
      SWAP    = 3'd7
   } state_t;

   localparam logic [21:0] TIMEOUT_CYCLES_DEFAULT = 22'd2_000_000;

   // REQ state that follows a completed ACK, skipping stages that are built out.
   function automatic state_t nextAfterAck(state_t ackState, bit filterEn, bit minMaxEn);
      state_t nextState;
      nextState = SWAP;
      if (ackState == CAP_ACK && filterEn)
         nextState = FLT_REQ;
      else if ((ackState == CAP_ACK || ackState == FLT_ACK) && minMaxEn)
         nextState = MM_REQ;
      return nextState;
   endfunction

endpackage

// File: rtl/stage_timer.sv
// Per-state watchdog: counts cycles spent in one state and flags the last
// permitted cycle.
module stage_timer
   import frame_seq_pkg::*;
#(
   parameter logic [21:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic enable,
   output logic expired
);

   logic [21:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_count <= '0;
      else if (restart)
         r_count <= '0;
      else if (enable)
         r_count <= r_count + 22'd1;
   end

   assign expired = enable && (r_count == TIMEOUT_CYCLES - 22'd1);

endmodule

// File: rtl/frame_pipe_sequencer.sv
// Frame loop sequencer: capture -> filter -> min/max -> buffer swap on vsync,
// with 4-phase handshakes per stage and a per-state watchdog.
module frame_pipe_sequencer
   import frame_seq_pkg::*;
#(
   parameter logic [21:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter bit          FILTER_EN      = 1'b1,
   parameter bit          MINMAX_EN      = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       frame_vs,
   input  logic       clear_err,
   input  logic       photo_done,
   input  logic       filter_done,
   input  logic       min_max_done,
   output logic       photo_start,
   output logic       photo_ack,
   output logic       filter_start,
   output logic       filter_ack,
   output logic       min_max_start,
   output logic       min_max_ack,
   output logic       image_sel,
   output logic [2:0] state,
   output logic [7:0] frame_count,
   output logic       busy,
   output logic       timeout_err
);

   state_t      r_state;
   state_t      w_nextState;
   logic        r_vsPrev;
   logic        r_imageSel;
   logic [7:0]  r_frameCount;
   logic        r_busy;
   logic        r_timeoutErr;
   logic        r_photoStart, r_photoAck;
   logic        r_filterStart, r_filterAck;
   logic        r_minMaxStart, r_minMaxAck;
   logic        w_expired;
   logic        w_vsRise;
   logic        w_swap;

   assign w_vsRise = frame_vs && !r_vsPrev;

   stage_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_stageTimer (
      .clk    (clk),
      .reset  (reset),
      .restart(w_nextState != r_state),
      .enable (r_state != IDLE),
      .expired(w_expired)
   );

   always_comb begin
      w_nextState = r_state;
      w_swap      = 1'b0;
      unique case (r_state)
         IDLE:    if (run)           w_nextState = CAP_REQ;
         CAP_REQ: if (photo_done)    w_nextState = CAP_ACK;
         CAP_ACK: if (!photo_done)   w_nextState = nextAfterAck(CAP_ACK, FILTER_EN, MINMAX_EN);
         FLT_REQ: if (filter_done)   w_nextState = FLT_ACK;
         FLT_ACK: if (!filter_done)  w_nextState = nextAfterAck(FLT_ACK, FILTER_EN, MINMAX_EN);
         MM_REQ:  if (min_max_done)  w_nextState = MM_ACK;
         MM_ACK:  if (!min_max_done) w_nextState = SWAP;
         SWAP: begin
            // A watchdog expiry here still swaps so the display never freezes.
            if (w_vsRise || w_expired) begin
               w_swap      = 1'b1;
               w_nextState = run ? CAP_REQ : IDLE;
            end
         end
      endcase
      if (w_expired && r_state != SWAP)
         w_nextState = IDLE;
   end

   // Outputs are decoded from the next state so they change on the entering edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_vsPrev      <= 1'b0;
         r_imageSel    <= 1'b1;
         r_frameCount  <= 8'd0;
         r_busy        <= 1'b0;
         r_timeoutErr  <= 1'b0;
         r_photoStart  <= 1'b0;
         r_photoAck    <= 1'b0;
         r_filterStart <= 1'b0;
         r_filterAck   <= 1'b0;
         r_minMaxStart <= 1'b0;
         r_minMaxAck   <= 1'b0;
      end else begin
         r_state       <= w_nextState;
         r_vsPrev      <= frame_vs;
         r_busy        <= (w_nextState != IDLE);
         r_photoStart  <= (w_nextState == CAP_REQ);
         r_photoAck    <= (w_nextState == CAP_ACK);
         r_filterStart <= (w_nextState == FLT_REQ);
         r_filterAck   <= (w_nextState == FLT_ACK);
         r_minMaxStart <= (w_nextState == MM_REQ);
         r_minMaxAck   <= (w_nextState == MM_ACK);
         if (w_swap) begin
            r_imageSel   <= ~r_imageSel;
            r_frameCount <= r_frameCount + 8'd1;
         end
         if (w_expired)
            r_timeoutErr <= 1'b1;
         else if (clear_err)
            r_timeoutErr <= 1'b0;
      end
   end

   assign photo_start   = r_photoStart;
   assign photo_ack     = r_photoAck;
   assign filter_start  = r_filterStart;
   assign filter_ack    = r_filterAck;
   assign min_max_start = r_minMaxStart;
   assign min_max_ack   = r_minMaxAck;
   assign image_sel     = r_imageSel;
   assign state         = r_state;
   assign frame_count   = r_frameCount;
   assign busy          = r_busy;
   assign timeout_err   = r_timeoutErr;

endmodule

// File: tb/tb_frame_pipe_sequencer.sv
// Bench for frame_pipe_sequencer: two instances (full pipeline, and a short
// watchdog with filter and min/max built out) checked against a route-table model.
module tb_frame_pipe_sequencer;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic run, frameVs, clearErr;
   logic [2:0] doneV [2];

   wire  [5:0] hsW    [2];
   wire  [2:0] stateW [2];
   wire  [7:0] cntW   [2];
   wire  [1:0] selW, busyW, errW;

   int   vectors = 0;
   int   miscompares = 0;
   bit   checkEn, randomMode, traceOn, sawBFltMm;
   bit   stuck [2][3];
   int   respCnt [2][3];
   int   respDelay [2][3];
   int   traceB [$];

   // Model state: position along each instance's stage route, cycles in state.
   int   route [2][8];
   int   timeoutOf [2] = '{128, 16};
   int   mPos [2], mAge [2], mCnt [2];
   logic mSel [2], mErr [2];
   logic mVsPrev;

   always #5 clk = ~clk;

   frame_pipe_sequencer #(.TIMEOUT_CYCLES(22'd128), .FILTER_EN(1'b1), .MINMAX_EN(1'b1)) dutA (
      .clk(clk), .reset(reset), .run(run), .frame_vs(frameVs), .clear_err(clearErr),
      .photo_done(doneV[0][0]), .filter_done(doneV[0][1]), .min_max_done(doneV[0][2]),
      .photo_start(hsW[0][0]), .photo_ack(hsW[0][1]), .filter_start(hsW[0][2]),
      .filter_ack(hsW[0][3]), .min_max_start(hsW[0][4]), .min_max_ack(hsW[0][5]),
      .image_sel(selW[0]), .state(stateW[0]), .frame_count(cntW[0]),
      .busy(busyW[0]), .timeout_err(errW[0]));

   frame_pipe_sequencer #(.TIMEOUT_CYCLES(22'd16), .FILTER_EN(1'b0), .MINMAX_EN(1'b0)) dutB (
      .clk(clk), .reset(reset), .run(run), .frame_vs(frameVs), .clear_err(clearErr),
      .photo_done(doneV[1][0]), .filter_done(doneV[1][1]), .min_max_done(doneV[1][2]),
      .photo_start(hsW[1][0]), .photo_ack(hsW[1][1]), .filter_start(hsW[1][2]),
      .filter_ack(hsW[1][3]), .min_max_start(hsW[1][4]), .min_max_ack(hsW[1][5]),
      .image_sel(selW[1]), .state(stateW[1]), .frame_count(cntW[1]),
      .busy(busyW[1]), .timeout_err(errW[1]));

   function automatic int stateOf(int i); return int'(stateW[i]); endfunction
   function automatic int hsOf(int i);    return int'(hsW[i]);    endfunction
   function automatic int cntOf(int i);   return int'(cntW[i]);   endfunction
   function automatic int selOf(int i);   return int'(selW[i]);   endfunction
   function automatic int busyOf(int i);  return int'(busyW[i]);  endfunction
   function automatic int errOf(int i);   return int'(errW[i]);   endfunction

   function automatic int codeOf(int i);
      return (mPos[i] == 0) ? 0 : route[i][mPos[i] - 1];
   endfunction

   function automatic bit doneFor(int i, int code);
      if (code >= 1 && code <= 6) return doneV[i][(code - 1) / 2];
      return 1'b0;
   endfunction

   task automatic checkOutput(input string name, input int inst, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s[%0d] got %0d expected %0d at %0t", name, inst, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic v, input logic c);
      @(negedge clk);
      run = r; frameVs = v; clearErr = c;
   endtask

   // Odd codes are REQ (advance on done=1), even codes ACK (advance on done=0).
   task automatic modelStep(input int i);
      int cur, nxt;
      bit expired, rise, done;
      cur     = codeOf(i);
      nxt     = mPos[i];
      expired = (cur != 0) && (mAge[i] == timeoutOf[i] - 1);
      rise    = frameVs && !mVsPrev;
      done    = doneFor(i, cur);
      if (cur == 0) begin
         if (run) nxt = 1;
      end else if (cur == 7) begin
         if (rise || expired) begin
            mSel[i] = ~mSel[i];
            mCnt[i] = (mCnt[i] + 1) % 256;
            nxt     = run ? 1 : 0;
         end
      end else if (expired) begin
         nxt = 0;
      end else if ((cur % 2 == 1) == done) begin
         nxt = mPos[i] + 1;
      end
      if (expired) mErr[i] = 1'b1;
      else if (clearErr) mErr[i] = 1'b0;
      mAge[i] = (nxt != mPos[i]) ? 0 : ((cur != 0) ? mAge[i] + 1 : 0);
      mPos[i] = nxt;
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            mPos[i] = 0; mAge[i] = 0; mCnt[i] = 0; mSel[i] = 1'b1; mErr[i] = 1'b0;
         end
         mVsPrev = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) modelStep(i);
         mVsPrev = frameVs;
      end
   end

   task automatic compareInst(input int i);
      int code, hsExp;
      code  = codeOf(i);
      hsExp = (code >= 1 && code <= 6) ? (1 << (code - 1)) : 0;
      checkOutput("state", i, stateOf(i), code);
      checkOutput("handshake", i, hsOf(i), hsExp);
      checkOutput("image_sel", i, selOf(i), int'(mSel[i]));
      checkOutput("frame_count", i, cntOf(i), mCnt[i]);
      checkOutput("busy", i, busyOf(i), (code != 0) ? 1 : 0);
      checkOutput("timeout_err", i, errOf(i), int'(mErr[i]));
   endtask

   initial forever begin
      @(negedge clk);
      if (checkEn) for (int i = 0; i < 2; i++) compareInst(i);
   end

   // Stage responders: done rises after start has been seen for a delay, falls after ack.
   initial begin
      doneV[0] = 3'b000;
      doneV[1] = 3'b000;
      for (int i = 0; i < 2; i++) for (int s = 0; s < 3; s++) begin
         respCnt[i][s] = 0; respDelay[i][s] = 3;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) for (int s = 0; s < 3; s++) begin
            if (hsW[i][2*s] && !doneV[i][s] && !stuck[i][s]) begin
               respCnt[i][s]++;
               if (respCnt[i][s] >= respDelay[i][s]) begin
                  doneV[i][s] = 1'b1; respCnt[i][s] = 0;
                  respDelay[i][s] = randomMode ? int'($urandom_range(1, 3)) : 2;
               end
            end else if (hsW[i][2*s+1] && doneV[i][s]) begin
               respCnt[i][s]++;
               if (respCnt[i][s] >= respDelay[i][s]) begin
                  doneV[i][s] = 1'b0; respCnt[i][s] = 0;
                  respDelay[i][s] = randomMode ? int'($urandom_range(1, 4)) : 3;
               end
            end else begin
               respCnt[i][s] = 0;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (traceOn && (traceB.size() == 0 || traceB[traceB.size() - 1] != stateOf(1)))
         traceB.push_back(stateOf(1));
      if (checkEn && hsW[1][5:2] != 4'b0000) sawBFltMm = 1'b1;
   end

   task automatic waitState(input int i, input int code, input int limit, input string tag);
      int n;
      n = 0;
      while (stateOf(i) != code && n < limit) begin
         applyStimulus(run, randomMode ? (($urandom_range(0, 2) == 0) ? ~frameVs : frameVs) : 1'b0, 1'b0);
         n++;
      end
      checkOutput(tag, i, stateOf(i), code);
   endtask

   task automatic countInState(input int i, input int code, output int n);
      n = 0;
      while (stateOf(i) == code && n < 400) begin
         n++;
         applyStimulus(run, 1'b0, 1'b0);
      end
   endtask

   initial begin
      int expTrace [4] = '{0, 1, 2, 7};
      int n, c0, s0, swaps, lastC, cycles;
      route[0] = '{1, 2, 3, 4, 5, 6, 7, 0};
      route[1] = '{1, 2, 7, 0, 0, 0, 0, 0};
      run = 1'b0; frameVs = 1'b0; clearErr = 1'b0;
      checkEn = 1'b0; randomMode = 1'b0; traceOn = 1'b0; sawBFltMm = 1'b0;
      for (int i = 0; i < 2; i++) for (int s = 0; s < 3; s++) stuck[i][s] = 1'b0;

      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checkOutput("rstState", i, stateOf(i), 0);
         checkOutput("rstSel", i, selOf(i), 1);
         checkOutput("rstCount", i, cntOf(i), 0);
         checkOutput("rstBusy", i, busyOf(i), 0);
         checkOutput("rstErr", i, errOf(i), 0);
         checkOutput("rstHandshake", i, hsOf(i), 0);
      end
      @(negedge clk);
      reset = 1'b1; checkEn = 1'b1; traceOn = 1'b1;
      repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("idleWithoutRun", 0, stateOf(0), 0);

      // Directed full loop with a single vsync pulse at cycle 100.
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (99) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("loopSel", 0, selOf(0), 0);
      checkOutput("loopCount", 0, cntOf(0), 1);
      checkOutput("loopState", 0, stateOf(0), 1);
      checkOutput("traceLen", 1, (traceB.size() >= 4) ? 1 : 0, 1);
      for (int k = 0; k < 4 && k < traceB.size(); k++)
         checkOutput("traceB", k, traceB[k], expTrace[k]);
      traceOn = 1'b0;

      // Filter stalls on the full pipeline: watchdog abort after 128 cycles.
      stuck[0][1] = 1'b1;
      waitState(0, 3, 200, "reachFltReq");
      s0 = selOf(0);
      countInState(0, 3, n);
      checkOutput("fltTimeoutLen", 0, n, 128);
      checkOutput("fltTimeoutState", 0, stateOf(0), 0);
      checkOutput("fltStartDropped", 0, int'(hsW[0][2]), 0);
      checkOutput("fltTimeoutErr", 0, errOf(0), 1);
      checkOutput("fltNoSwap", 0, selOf(0), s0);
      stuck[0][1] = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("clearErr", 0, errOf(0), 0);

      // Capture stalls on the short-watchdog instance.
      waitState(1, 7, 100, "bReachSwap");
      stuck[1][0] = 1'b1;
      waitState(1, 1, 100, "bReachCapReq");
      countInState(1, 1, n);
      checkOutput("capTimeoutLen", 1, n, 16);
      checkOutput("capTimeoutState", 1, stateOf(1), 0);
      checkOutput("capStartDropped", 1, int'(hsW[1][0]), 0);
      checkOutput("capTimeoutErr", 1, errOf(1), 1);
      stuck[1][0] = 1'b0;

      // Randomised run until the full pipeline has swapped 256 times.
      randomMode = 1'b1;
      c0 = cntOf(0); s0 = selOf(0); lastC = c0; swaps = 0; cycles = 0;
      while (swaps < 256 && cycles < 30000) begin
         if ($urandom_range(0, 99) == 0) stuck[1][0] = ~stuck[1][0];
         applyStimulus($urandom_range(0, 19) != 0,
                       ($urandom_range(0, 2) == 0) ? ~frameVs : frameVs,
                       $urandom_range(0, 39) == 0);
         cycles++;
         if (cntOf(0) != lastC) begin swaps++; lastC = cntOf(0); end
      end
      stuck[1][0] = 1'b0;
      checkOutput("wrapSwaps", 0, swaps, 256);
      checkOutput("wrapCount", 0, cntOf(0), c0);
      checkOutput("wrapSel", 0, selOf(0), s0);

      // Dropping run in MM_ACK finishes the frame, then parks in IDLE.
      run = 1'b1;
      waitState(0, 6, 600, "reachMmAck");
      c0 = cntOf(0);
      run = 1'b0;
      waitState(0, 0, 400, "stopToIdle");
      checkOutput("stopCount", 0, cntOf(0), (c0 + 1) % 256);
      repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("stopStays", 0, stateOf(0), 0);

      // Vsync during CAP_ACK is ignored; reset mid-handshake clears immediately.
      randomMode = 1'b0;
      run = 1'b1; frameVs = 1'b0;
      waitState(0, 2, 300, "reachCapAck");
      s0 = selOf(0);
      frameVs = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("vsIgnoredSel", 0, selOf(0), s0);
      checkOutput("ackBeforeReset", 0, int'(hsW[0][1]), 1);
      #2 reset = 1'b0;
      #1;
      checkOutput("asyncAck", 0, int'(hsW[0][1]), 0);
      checkOutput("asyncSel", 0, selOf(0), 1);
      checkOutput("asyncState", 0, stateOf(0), 0);
      checkOutput("asyncCount", 0, cntOf(0), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("bNoFltMm", 1, int'(sawBFltMm), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog simulation did not finish at %0t", $time);
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
